// File: rtl/dram_resp_pkg.sv
// Shared types and constants for the DRAM strobe responder.
// pack_addr builds the backend address as {bank, row, col}, bank at the MSB.
package dram_resp_pkg;
  localparam int MA_W      = 11;
  localparam int DATA_W    = 64;
  localparam int BANKS     = 2;
  localparam int BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int BE_W      = DATA_W / 8;
  localparam int OE_W      = 3;
  localparam int ADDR_W    = BANK_W + 2 * MA_W;
  localparam int REFRESH_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    HOLD    = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [BANK_W-1:0] bank,
                                                  input logic [MA_W-1:0]   row,
                                                  input logic [MA_W-1:0]   col);
    return {bank, row, col};
  endfunction
endpackage

// File: rtl/dram_resp_if.sv
// Controller-side strobe pins plus the backend request port.
// Backend handshake: mem_req rises with addr/we/be/wdata stable and stays high
// until a one-cycle mem_ack; mem_rdata is valid in the mem_ack cycle.
interface dram_resp_if;
  import dram_resp_pkg::*;

  logic [BANKS-1:0]     rasl;
  logic [BANKS-1:0]     casl;
  logic [OE_W-1:0]      oel;
  logic [BE_W-1:0]      wel;
  logic [MA_W-1:0]      ma;
  logic [DATA_W-1:0]    din;
  logic [DATA_W-1:0]    dout;
  logic                 d_oe;
  logic                 ram_rdy;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [BE_W-1:0]      mem_be;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata;
  logic                 mem_ack;
  logic [REFRESH_W-1:0] refresh_cnt;
  logic                 proto_err;

  modport slave (
    input  rasl, casl, oel, wel, ma, din, mem_rdata, mem_ack,
    output dout, d_oe, ram_rdy, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           refresh_cnt, proto_err
  );

  modport master (
    output rasl, casl, oel, wel, ma, din, mem_rdata, mem_ack,
    input  dout, d_oe, ram_rdy, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           refresh_cnt, proto_err
  );
endinterface

// File: rtl/dram_resp_edge.sv
// Registers one active-low strobe and flags its edges against the registered copy.
module dram_resp_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic strobe_q_o,
  output logic fall_o,
  output logic rise_o
);
  logic strobe_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) strobe_q <= 1'b1;
    else       strobe_q <= strobe_i;
  end

  assign strobe_q_o = strobe_q;
  assign fall_o     = strobe_q & ~strobe_i;
  assign rise_o     = ~strobe_q & strobe_i;
endmodule

// File: rtl/dram_resp.sv
// Turns RAS/CAS strobe activity into single backend requests, with CBR refresh
// counting, a one-entry pending slot for simultaneous CAS, and ram_rdy throttling.
module dram_resp
  import dram_resp_pkg::*;
(
  input  logic       sys_clk,
  input  logic       reset,
  dram_resp_if.slave bus,
  output state_e     state_o
);
  logic [BANKS-1:0]     rasl_q, casl_q, ras_fall, ras_rise, cas_fall, cas_rise;
  state_e               state_q, state_d;
  logic [BANKS-1:0]     open_q, open_d, arm_q, arm_d;
  logic [MA_W-1:0]      row_q [BANKS];
  logic [MA_W-1:0]      row_d [BANKS];
  logic                 pend_valid_q, pend_valid_d, pend_we_q, pend_we_d;
  logic [ADDR_W-1:0]    pend_addr_q, pend_addr_d, mem_addr_q, mem_addr_d;
  logic [BE_W-1:0]      pend_be_q, pend_be_d, mem_be_q, mem_be_d;
  logic [DATA_W-1:0]    pend_wdata_q, pend_wdata_d, mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic                 mem_we_q, mem_we_d, ram_rdy_q, ram_rdy_d;
  logic                 proto_err_q, proto_err_d;
  logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;
  logic                 cur_free, accepted, cas_we;
  logic [BE_W-1:0]      cas_be;
  logic [BANK_W-1:0]    cur_bank;

  for (genvar g = 0; g < BANKS; g++) begin : g_edge
    dram_resp_edge u_ras (.clk_i(sys_clk), .rst_i(reset), .strobe_i(bus.rasl[g]),
                          .strobe_q_o(rasl_q[g]), .fall_o(ras_fall[g]), .rise_o(ras_rise[g]));
    dram_resp_edge u_cas (.clk_i(sys_clk), .rst_i(reset), .strobe_i(bus.casl[g]),
                          .strobe_q_o(casl_q[g]), .fall_o(cas_fall[g]), .rise_o(cas_rise[g]));
  end

  assign cas_we   = ~&bus.wel;
  assign cas_be   = cas_we ? ~bus.wel : '1;
  assign cur_bank = mem_addr_q[ADDR_W-1 -: BANK_W];

  always_comb begin
    state_d       = state_q;
    open_d        = open_q;
    arm_d         = arm_q;
    row_d         = row_q;
    pend_valid_d  = pend_valid_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_be_d     = pend_be_q;
    pend_wdata_d  = pend_wdata_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    dout_d        = dout_q;
    ram_rdy_d     = ram_rdy_q;
    refresh_cnt_d = refresh_cnt_q;
    proto_err_d   = proto_err_q;
    cur_free      = 1'b0;
    accepted      = 1'b0;

    // A CAS that falls on a closed bank while RAS is high may be the first half
    // of a CBR refresh; it only becomes an error if CAS rises without a RAS fall.
    for (int b = 0; b < BANKS; b++) begin
      if (ras_fall[b]) begin
        if (!casl_q[b]) begin
          refresh_cnt_d = refresh_cnt_d + 16'd1;
          arm_d[b]      = 1'b0;
        end else begin
          open_d[b] = 1'b1;
          row_d[b]  = bus.ma;
        end
      end else if (ras_rise[b]) begin
        open_d[b] = 1'b0;
      end
      if (cas_fall[b] && !open_q[b]) begin
        if (rasl_q[b]) arm_d[b]    = 1'b1;
        else           proto_err_d = 1'b1;
      end else if (cas_rise[b] && arm_q[b]) begin
        arm_d[b]    = 1'b0;
        proto_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          mem_we_d     = pend_we_q;
          mem_addr_d   = pend_addr_q;
          mem_be_d     = pend_be_q;
          mem_wdata_d  = pend_wdata_q;
          pend_valid_d = 1'b0;
          state_d      = REQ;
        end else begin
          cur_free = 1'b1;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            dout_d  = bus.mem_rdata;
            state_d = HOLD;
          end
          if (!pend_valid_q) ram_rdy_d = 1'b1;
        end
      end
      HOLD: begin
        if (bus.casl[cur_bank]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bank 0 wins the free slot; a second same-cycle CAS lands in pending.
    for (int b = 0; b < BANKS; b++) begin
      if (cas_fall[b] && open_q[b]) begin
        accepted = 1'b1;
        if (cur_free) begin
          mem_we_d    = cas_we;
          mem_addr_d  = pack_addr(BANK_W'(b), row_q[b], bus.ma);
          mem_be_d    = cas_be;
          mem_wdata_d = bus.din;
          state_d     = REQ;
          cur_free    = 1'b0;
        end else if (!pend_valid_d) begin
          pend_we_d    = cas_we;
          pend_addr_d  = pack_addr(BANK_W'(b), row_q[b], bus.ma);
          pend_be_d    = cas_be;
          pend_wdata_d = bus.din;
          pend_valid_d = 1'b1;
        end else begin
          proto_err_d = 1'b1;
        end
      end
    end
    if (accepted) ram_rdy_d = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      open_q        <= '0;
      arm_q         <= '0;
      row_q         <= '{default: '0};
      pend_valid_q  <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_be_q     <= '0;
      pend_wdata_q  <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      dout_q        <= '0;
      ram_rdy_q     <= 1'b1;
      refresh_cnt_q <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      open_q        <= open_d;
      arm_q         <= arm_d;
      row_q         <= row_d;
      pend_valid_q  <= pend_valid_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_be_q     <= pend_be_d;
      pend_wdata_q  <= pend_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      dout_q        <= dout_d;
      ram_rdy_q     <= ram_rdy_d;
      refresh_cnt_q <= refresh_cnt_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bus.mem_req     = (state_q == REQ);
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.dout        = dout_q;
  assign bus.d_oe        = (state_q == HOLD) & ~&bus.oel & ~casl_q[cur_bank];
  assign bus.ram_rdy     = ram_rdy_q;
  assign bus.refresh_cnt = refresh_cnt_q;
  assign bus.proto_err   = proto_err_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_dram_resp.sv
// Directed bench for dram_resp: a backend model acks requests and checks them
// against an expected-transaction queue; a dout monitor checks read data.
module tb_dram_resp;
  import dram_resp_pkg::*;

  localparam int TW = 1 + ADDR_W + BE_W + DATA_W;

  logic   sys_clk;
  logic   reset;
  state_e state;
  dram_resp_if bus ();

  dram_resp u_dut (.sys_clk(sys_clk), .reset(reset), .bus(bus), .state_o(state));

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int ack_cnt   = 0;
  int ack_total = 0;
  int req_cycles = 0;
  logic [DATA_W-1:0] bk_rdata = '0;
  logic doe_prev = 1'b0;

  logic [TW-1:0]     exp_q[$];
  logic [DATA_W-1:0] rd_q[$];

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] txn(input logic we, input logic bank,
                                        input logic [10:0] row, input logic [10:0] col,
                                        input logic [7:0] be, input logic [63:0] wdata);
    return {we, bank, row, col, be, wdata};
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] c, input logic [10:0] a,
                       input logic [7:0] w, input logic [63:0] d);
    @(negedge sys_clk);
    bus.rasl = r;
    bus.casl = c;
    bus.ma   = a;
    bus.wel  = w;
    bus.din  = d;
  endtask

  task automatic wait_rdy(input string name);
    int k;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!bus.ram_rdy && k < 100);
    if (!bus.ram_rdy) check({name, "_rdy_timeout"}, 1'b0, 1'b1);
  endtask

  // backend model and transaction scoreboard
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge sys_clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) req_cycles++;
      if (!bus.mem_req) begin
        ack_cnt = 0;
      end else if (ack_cnt >= ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bk_rdata;
        ack_cnt = 0;
        ack_total++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL txn: unexpected request %h", {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata});
        end else begin
          check("txn", {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata}, exp_q.pop_front());
        end
      end else begin
        ack_cnt++;
      end
    end
  end

  // read data monitor: one expected word per d_oe assertion
  always @(negedge sys_clk) begin
    if (bus.d_oe && !doe_prev) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dout: unexpected drive %h", bus.dout);
      end else begin
        check("dout", bus.dout, rd_q.pop_front());
      end
    end
    doe_prev = bus.d_oe;
  end

  initial begin
    int lowcnt, acks0, reqs0;
    reset    = 1'b1;
    bus.rasl = 2'b11;
    bus.casl = 2'b11;
    bus.oel  = 3'b111;
    bus.wel  = 8'hFF;
    bus.ma   = '0;
    bus.din  = '0;
    cyc(3);
    check("rst_mem_req",  bus.mem_req, 1'b0);
    check("rst_ram_rdy",  bus.ram_rdy, 1'b1);
    check("rst_d_oe",     bus.d_oe, 1'b0);
    check("rst_dout",     bus.dout, 64'h0);
    check("rst_mem_addr", bus.mem_addr, 23'h0);
    check("rst_mem_be",   bus.mem_be, 8'h0);
    check("rst_refresh",  bus.refresh_cnt, 16'h0);
    check("rst_proto",    bus.proto_err, 1'b0);
    check("rst_state",    state, IDLE);
    reset = 1'b0;
    cyc(2);

    // page-mode read on bank 0
    bk_rdata = 64'hDEADBEEF_00000001;
    drive(2'b10, 2'b11, 11'h123, 8'hFF, 64'h0);
    exp_q.push_back(txn(1'b0, 1'b0, 11'h123, 11'h004, 8'hFF, 64'h0));
    rd_q.push_back(64'hDEADBEEF_00000001);
    drive(2'b10, 2'b10, 11'h004, 8'hFF, 64'h0);
    wait_rdy("rd0");
    check("rd0_doe_oel_high", bus.d_oe, 1'b0);
    bus.oel = 3'b110;
    cyc(1);
    check("rd0_doe_on", bus.d_oe, 1'b1);
    check("rd0_dout", bus.dout, 64'hDEADBEEF_00000001);
    drive(2'b10, 2'b11, 11'h004, 8'hFF, 64'h0);
    cyc(1);
    check("rd0_doe_cas_high", bus.d_oe, 1'b0);
    bus.oel = 3'b111;
    bk_rdata = 64'hDEADBEEF_00000002;
    exp_q.push_back(txn(1'b0, 1'b0, 11'h123, 11'h005, 8'hFF, 64'h0));
    rd_q.push_back(64'hDEADBEEF_00000002);
    drive(2'b10, 2'b10, 11'h005, 8'hFF, 64'h0);
    wait_rdy("rd1");
    bus.oel = 3'b011;
    cyc(1);
    check("rd1_doe_on", bus.d_oe, 1'b1);
    drive(2'b10, 2'b11, 11'h005, 8'hFF, 64'h0);
    bus.oel = 3'b111;
    drive(2'b11, 2'b11, 11'h000, 8'hFF, 64'h0);
    cyc(2);

    // byte write on bank 1, two-cycle ack delay
    ack_delay = 2;
    drive(2'b01, 2'b11, 11'h7FF, 8'hFF, 64'h0);
    exp_q.push_back(txn(1'b1, 1'b1, 11'h7FF, 11'h010, 8'h0F, 64'h1122334455667788));
    drive(2'b01, 2'b01, 11'h010, 8'hF0, 64'h1122334455667788);
    lowcnt = 0;
    do begin
      @(negedge sys_clk);
      if (!bus.ram_rdy) lowcnt++;
    end while (!bus.ram_rdy && lowcnt < 50);
    check("wr_rdy_low_cycles", lowcnt, 3);
    drive(2'b01, 2'b11, 11'h000, 8'hFF, 64'h0);
    drive(2'b11, 2'b11, 11'h000, 8'hFF, 64'h0);
    cyc(2);

    // simultaneous CAS on both open banks, delayed acks
    ack_delay = 5;
    drive(2'b00, 2'b11, 11'h055, 8'hFF, 64'h0);
    exp_q.push_back(txn(1'b1, 1'b0, 11'h055, 11'h020, 8'hFF, 64'hA5A5A5A5A5A5A5A5));
    exp_q.push_back(txn(1'b1, 1'b1, 11'h055, 11'h020, 8'hFF, 64'hA5A5A5A5A5A5A5A5));
    acks0 = ack_total;
    drive(2'b00, 2'b00, 11'h020, 8'h00, 64'hA5A5A5A5A5A5A5A5);
    wait_rdy("dual");
    check("dual_acks_before_rdy", ack_total - acks0, 2);
    drive(2'b00, 2'b11, 11'h000, 8'hFF, 64'h0);
    drive(2'b11, 2'b11, 11'h000, 8'hFF, 64'h0);
    ack_delay = 0;
    cyc(3);

    // three CBR refreshes on bank 0
    reqs0 = req_cycles;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 2'b10, 11'h000, 8'hFF, 64'h0);
      drive(2'b10, 2'b10, 11'h000, 8'hFF, 64'h0);
      drive(2'b11, 2'b10, 11'h000, 8'hFF, 64'h0);
      drive(2'b11, 2'b11, 11'h000, 8'hFF, 64'h0);
    end
    cyc(2);
    check("cbr_refresh_cnt", bus.refresh_cnt, 16'd3);
    check("cbr_no_req", req_cycles - reqs0, 0);
    check("cbr_no_proto", bus.proto_err, 1'b0);

    // CAS on a closed bank without a following RAS
    drive(2'b11, 2'b10, 11'h001, 8'hFF, 64'h0);
    drive(2'b11, 2'b10, 11'h001, 8'hFF, 64'h0);
    drive(2'b11, 2'b11, 11'h001, 8'hFF, 64'h0);
    cyc(2);
    check("proto_set", bus.proto_err, 1'b1);
    cyc(5);
    check("proto_sticky", bus.proto_err, 1'b1);
    check("proto_no_req", req_cycles - reqs0, 0);

    // reset while a request is outstanding
    ack_delay = 20;
    drive(2'b10, 2'b11, 11'h001, 8'hFF, 64'h0);
    drive(2'b10, 2'b10, 11'h002, 8'hFF, 64'h0);
    cyc(2);
    check("mid_req_high", bus.mem_req, 1'b1);
    @(negedge sys_clk);
    reset = 1'b1;
    #1;
    check("mid_req_dropped", bus.mem_req, 1'b0);
    bus.rasl = 2'b11;
    bus.casl = 2'b11;
    ack_delay = 0;
    cyc(2);
    reset = 1'b0;
    cyc(2);
    check("post_rst_rdy", bus.ram_rdy, 1'b1);
    check("post_rst_refresh", bus.refresh_cnt, 16'h0);
    check("post_rst_proto", bus.proto_err, 1'b0);
    check("post_rst_mem_req", bus.mem_req, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
